// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and result type for the register-file write-back stage
package rf_pkg;

  localparam int REG_ADDR_W        = 5;
  localparam int XLEN_DEFAULT      = 32;
  localparam int AGE_LIMIT_DEFAULT = 3;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_result;

endpackage

// File: rtl/wb_hold_buf.sv
// rtl/wb_hold_buf.sv - one-entry holding buffer for a single write-back source
module wb_hold_buf
  import rf_pkg::*;
#(
  parameter int W = REG_ADDR_W + XLEN_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_drain,
  input  logic [W-1:0] i_payload,
  output logic         o_valid,
  output logic [W-1:0] o_payload
);

  logic         valid_q, valid_d;
  logic [W-1:0] payload_q, payload_d;

  // a load refills the entry even in the cycle the old entry drains
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (i_drain) begin
      valid_d = 1'b0;
    end
    if (i_load) begin
      valid_d   = 1'b1;
      payload_d = i_payload;
    end
  end

  // entry storage, emptied immediately on reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_payload = payload_q;

endmodule

// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - ALU/LSU write-back arbiter with optional busy scoreboard (RF_WB_SCOREBOARD_EN)
module rf_writeback
  import rf_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int AGE_LIMIT = AGE_LIMIT_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_alu_valid,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]       i_alu_data,
  output logic                  o_alu_ready,
  input  logic                  i_lsu_valid,
  input  logic [REG_ADDR_W-1:0] i_lsu_rd,
  input  logic [XLEN-1:0]       i_lsu_data,
  output logic                  o_lsu_ready,
  output logic                  o_rd_wen,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]       o_rd_data,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy
);

  localparam int PW    = REG_ADDR_W + XLEN;
  localparam int AGE_W = (AGE_LIMIT < 1) ? 1 : $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  logic                  alu_full, lsu_full;
  logic [PW-1:0]         alu_pl, lsu_pl, win_pl;
  logic                  drain_alu, drain_lsu, age_force;
  logic [AGE_W-1:0]      age_q, age_d;
  logic                  wen_q, wen_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       data_q, data_d;

  wb_hold_buf #(.W(PW)) u_alu_buf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (i_alu_valid && o_alu_ready),
    .i_drain   (drain_alu),
    .i_payload ({i_alu_rd, i_alu_data}),
    .o_valid   (alu_full),
    .o_payload (alu_pl)
  );

  wb_hold_buf #(.W(PW)) u_lsu_buf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (i_lsu_valid && o_lsu_ready),
    .i_drain   (drain_lsu),
    .i_payload ({i_lsu_rd, i_lsu_data}),
    .o_valid   (lsu_full),
    .o_payload (lsu_pl)
  );

  // single drain per cycle: LSU first unless the ALU entry has waited too long
  always_comb begin
    age_force = alu_full && (age_q == AGE_MAX);
    drain_alu = alu_full && (!lsu_full || age_force);
    drain_lsu = lsu_full && !drain_alu;
  end

  assign o_alu_ready = !alu_full || drain_alu;
  assign o_lsu_ready = !lsu_full || drain_lsu;

  // register the drained result; rd 0 drains silently and idle cycles hold addr/data
  always_comb begin
    win_pl = drain_alu ? alu_pl : lsu_pl;
    wen_d  = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (drain_alu || drain_lsu) begin
      addr_d = win_pl[PW-1:XLEN];
      data_d = win_pl[XLEN-1:0];
      wen_d  = (addr_d != '0);
    end
    age_d = (alu_full && !drain_alu) ? age_q + 1'b1 : '0;
  end

  // write port and ALU starvation counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      age_q  <= '0;
    end else begin
      wen_q  <= wen_d;
      addr_q <= addr_d;
      data_q <= data_d;
      age_q  <= age_d;
    end
  end

  assign o_rd_wen  = wen_q;
  assign o_rd_addr = addr_q;
  assign o_rd_data = data_q;

`ifdef RF_WB_SCOREBOARD_EN
  localparam int NREGS = 1 << REG_ADDR_W;

  logic [NREGS-1:0] busy_q, busy_d;

  // clear on drain before setting on issue so a same-edge re-issue keeps the bit
  always_comb begin
    busy_d = busy_q;
    if (wen_d) begin
      busy_d[addr_d] = 1'b0;
    end
    if (i_issue_valid && (i_issue_rd != '0)) begin
      busy_d[i_issue_rd] = 1'b1;
    end
  end

  // pending-write map
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign o_rs1_busy = (i_rs1_addr != '0) && busy_q[i_rs1_addr];
  assign o_rs2_busy = (i_rs2_addr != '0) && busy_q[i_rs2_addr];
`else
  logic unused_scoreboard;
  assign unused_scoreboard = ^{i_issue_valid, i_issue_rd, i_rs1_addr, i_rs2_addr};
  assign o_rs1_busy = 1'b0;
  assign o_rs2_busy = 1'b0;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// tb/tb_rf_writeback.sv - randomized self-checking bench for rf_writeback against a behavioural model
module tb_rf_writeback;
  import rf_pkg::*;

  localparam int XLEN      = XLEN_DEFAULT;
  localparam int AGE_LIMIT = AGE_LIMIT_DEFAULT;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_alu_valid, i_lsu_valid, i_issue_valid;
  logic [4:0]      i_alu_rd, i_lsu_rd, i_issue_rd, i_rs1_addr, i_rs2_addr;
  logic [XLEN-1:0] i_alu_data, i_lsu_data;
  logic            o_alu_ready, o_lsu_ready, o_rd_wen, o_rs1_busy, o_rs2_busy;
  logic [4:0]      o_rd_addr;
  logic [XLEN-1:0] o_rd_data;

  rf_writeback #(.XLEN(XLEN), .AGE_LIMIT(AGE_LIMIT)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_alu_valid   (i_alu_valid),
    .i_alu_rd      (i_alu_rd),
    .i_alu_data    (i_alu_data),
    .o_alu_ready   (o_alu_ready),
    .i_lsu_valid   (i_lsu_valid),
    .i_lsu_rd      (i_lsu_rd),
    .i_lsu_data    (i_lsu_data),
    .o_lsu_ready   (o_lsu_ready),
    .o_rd_wen      (o_rd_wen),
    .o_rd_addr     (o_rd_addr),
    .o_rd_data     (o_rd_data),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .i_rs1_addr    (i_rs1_addr),
    .i_rs2_addr    (i_rs2_addr),
    .o_rs1_busy    (o_rs1_busy),
    .o_rs2_busy    (o_rs2_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // behavioural model: pending results per source, lost-arbitration count, visible write
  wb_result        m_alu, m_lsu;
  bit              m_alu_v, m_lsu_v, m_wen;
  int              m_wait;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;
  bit              m_busy [32];
  logic [XLEN-1:0] rf_ref [32] = '{default: '0};
  logic [XLEN-1:0] tb_rf  [32] = '{default: '0};

  // register file fed by the DUT write port
  always @(posedge i_clk) begin
    if (o_rd_wen) tb_rf[o_rd_addr] <= o_rd_data;
  end

  task automatic model_reset();
    m_alu_v = 0;
    m_lsu_v = 0;
    m_wen   = 0;
    m_wait  = 0;
    m_addr  = '0;
    m_data  = '0;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
  endtask

  // called at a falling edge: check state, drive inputs, advance model across the next rising edge
  task automatic cycle(input bit av, input logic [4:0] ar, input logic [XLEN-1:0] ad,
                       input bit lv, input logic [4:0] lr, input logic [XLEN-1:0] ld,
                       input bit iv, input logic [4:0] ir,
                       input logic [4:0] r1, input logic [4:0] r2);
    int       win;
    bit       a_rdy, l_rdy;
    wb_result w;
    win = 0;
    if (m_alu_v && (!m_lsu_v || m_wait >= AGE_LIMIT)) win = 2;
    else if (m_lsu_v) win = 1;
    a_rdy = !m_alu_v || (win == 2);
    l_rdy = !m_lsu_v || (win == 1);
    chk("rd_wen", o_rd_wen, m_wen);
    chk("rd_addr", o_rd_addr, m_addr);
    chk("rd_data", o_rd_data, m_data);
    chk("alu_ready", o_alu_ready, a_rdy);
    chk("lsu_ready", o_lsu_ready, l_rdy);
    i_alu_valid = av; i_alu_rd = ar; i_alu_data = ad;
    i_lsu_valid = lv; i_lsu_rd = lr; i_lsu_data = ld;
    i_issue_valid = iv; i_issue_rd = ir;
    i_rs1_addr = r1; i_rs2_addr = r2;
    #1;
    chk("rs1_busy", o_rs1_busy, (r1 != 0) && m_busy[r1]);
    chk("rs2_busy", o_rs2_busy, (r2 != 0) && m_busy[r2]);
    if (m_wen) rf_ref[m_addr] = m_data;
    m_wen = 0;
    w = (win == 2) ? m_alu : m_lsu;
    if (win != 0) begin
      m_addr = w.rd;
      m_data = w.data;
      m_wen  = (w.rd != 0);
`ifdef RF_WB_SCOREBOARD_EN
      if (w.rd != 0) m_busy[w.rd] = 0;
`endif
    end
`ifdef RF_WB_SCOREBOARD_EN
    if (iv && ir != 0) m_busy[ir] = 1;
`endif
    m_wait = (m_alu_v && win != 2) ? m_wait + 1 : 0;
    if (win == 2) m_alu_v = 0;
    if (win == 1) m_lsu_v = 0;
    if (av && a_rdy) begin m_alu_v = 1; m_alu.rd = ar; m_alu.data = ad; end
    if (lv && l_rdy) begin m_lsu_v = 1; m_lsu.rd = lr; m_lsu.data = ld; end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    i_rst = 1;
    i_alu_valid = 0; i_alu_rd = 0; i_alu_data = 0;
    i_lsu_valid = 0; i_lsu_rd = 0; i_lsu_data = 0;
    i_issue_valid = 0; i_issue_rd = 0; i_rs1_addr = 0; i_rs2_addr = 0;
    model_reset();
    #1;
    chk("reset_wen", o_rd_wen, 0);
    chk("reset_addr", o_rd_addr, 0);
    chk("reset_data", o_rd_data, 0);
    chk("reset_alu_ready", o_alu_ready, 1);
    chk("reset_lsu_ready", o_lsu_ready, 1);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 0;

    // ALU alone: written in the cycle after the drain edge, for one cycle
    cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_e0_wen", o_rd_wen, 0);
    idle(1);
    chk("alu_e1_wen", o_rd_wen, 1);
    chk("alu_e1_addr", o_rd_addr, 5);
    chk("alu_e1_data", o_rd_data, 32'hDEADBEEF);
    idle(1);
    chk("alu_e2_wen", o_rd_wen, 0);

    // same rd from both sources: LSU first, ALU last
    cycle(1, 3, 1, 1, 3, 2, 0, 0, 0, 0);
    idle(1);
    chk("same_rd_first", o_rd_data, 2);
    idle(1);
    chk("same_rd_second", o_rd_data, 1);
    chk("same_rd_second_wen", o_rd_wen, 1);
    idle(1);
    chk("same_rd_final", tb_rf[3], 1);

    // ALU starved by a continuous LSU stream until its age reaches the limit
    cycle(1, 9, 32'hA9, 1, 20, 32'h100, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk("contest_lsu_ready", o_lsu_ready, (k == 3) ? 0 : 1);
      cycle(0, 0, 0, 1, 5'(21 + k), 32'h200 + k, 0, 0, 0, 0);
    end
    chk("forced_alu_addr", o_rd_addr, 9);
    chk("forced_alu_data", o_rd_data, 32'hA9);
    idle(4);

    // rd 0 is accepted and drained without a write
    cycle(1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("rd0_wen", o_rd_wen, 0);
    chk("rd0_alu_ready", o_alu_ready, 1);
    idle(1);

    // scoreboard: busy from issue until drain; same-edge issue and drain stays busy
    cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
`ifdef RF_WB_SCOREBOARD_EN
    chk("sb_issue_busy", o_rs1_busy, 1);
`else
    chk("sb_off_busy", o_rs1_busy, 0);
`endif
    cycle(1, 7, 32'h77, 0, 0, 0, 0, 0, 7, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 7);
`ifdef RF_WB_SCOREBOARD_EN
    chk("sb_reissue_busy", o_rs2_busy, 1);
`endif
    cycle(1, 7, 32'h78, 0, 0, 0, 0, 0, 7, 0);
    idle(1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
    chk("sb_cleared", o_rs1_busy, 0);
    idle(1);

    // asynchronous reset with both buffers full and a write on the port
    cycle(1, 12, 32'hC0FFEE, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 10, 32'hA, 1, 11, 32'hB, 0, 0, 0, 0);
    chk("pre_reset_wen", o_rd_wen, 1);
    #2;
    i_rst = 1;
    #1;
    chk("async_reset_wen", o_rd_wen, 0);
    chk("async_reset_addr", o_rd_addr, 0);
    chk("async_reset_data", o_rd_data, 0);
    chk("async_reset_alu_ready", o_alu_ready, 1);
    chk("async_reset_lsu_ready", o_lsu_ready, 1);
    model_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("post_reset_wen", o_rd_wen, 0);
    end

    // randomized traffic with frequent rd collisions
    for (int n = 0; n < 1500; n++) begin
      cycle($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(4);
    for (int i = 1; i < 32; i++) chk($sformatf("reg%0d", i), tb_rf[i], rf_ref[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
